instr_fetch: RTL and testbench

INSTR_FETCH -- requirements
Module: instr_fetch

---
 rtl/instr_fetch.sv | 148 ++++++++++++++
 tb/tb_instr_fetch.sv | 257 +++++++++++++++++++++++++
 2 files changed

// File: rtl/instr_fetch.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : instr_fetch
//  Description : Instruction fetch stage. Issues one word-aligned request at a
//                time to instruction memory, registers the returned word with
//                its address for the decode stage, and absorbs a response that
//                arrives while the output is held in a one-entry skid buffer.
//                A taken branch redirects the PC and flushes the stage; a
//                response still in flight at that moment is discarded.
//  Ports       : clk, rst_n (async, active low)
//                stall_i                          - downstream hold
//                branch_taken_i, branch_target_i  - redirect request
//                imem_req_o, imem_addr_o          - memory request
//                imem_valid_i, imem_rdata_i       - memory response
//                if_valid_o, if_instr_o, if_pc_o, if_pc_plus4_o - fetch output
//  Revision    : 1.0 - initial release
// ============================================================================
module instr_fetch #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        stall_i,
  input  logic        branch_taken_i,
  input  logic [31:0] branch_target_i,
  output logic        imem_req_o,
  output logic [31:0] imem_addr_o,
  input  logic        imem_valid_i,
  input  logic [31:0] imem_rdata_i,
  output logic        if_valid_o,
  output logic [31:0] if_instr_o,
  output logic [31:0] if_pc_o,
  output logic [31:0] if_pc_plus4_o
);

  localparam logic [1:0] ST_REQ  = 2'd0;
  localparam logic [1:0] ST_WAIT = 2'd1;
  localparam logic [1:0] ST_HOLD = 2'd2;

  logic [1:0]  state;
  logic [31:0] pc_q;
  logic        discard;
  // Skid buffer occupancy is implied by ST_HOLD; no separate valid bit.
  logic [31:0] skid_instr;
  logic [31:0] skid_pc;
  logic        out_valid;
  logic [31:0] out_instr;
  logic [31:0] out_pc;

  logic        consume;
  logic        can_accept;
  logic        fire;
  logic [31:0] pc_inc;

  // Redirect targets are word aligned; the two low bits carry no meaning.
  logic        unused_target_lsbs;
  assign unused_target_lsbs = ^branch_target_i[1:0];

  assign consume    = out_valid & ~stall_i;
  assign can_accept = ~out_valid | consume;
  assign pc_inc     = pc_q + 32'd4;

  // The request strobe is combinational so that a freed output slot is refilled
  // in the same cycle. rst_n gates it because the reset state is ST_REQ with an
  // empty output, which would otherwise request during reset.
  assign fire = rst_n & (state == ST_REQ) & can_accept & ~branch_taken_i;

  assign imem_req_o    = fire;
  assign imem_addr_o   = pc_q;
  assign if_valid_o    = out_valid;
  assign if_instr_o    = out_instr;
  assign if_pc_o       = out_pc;
  assign if_pc_plus4_o = out_pc + 32'd4;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= ST_REQ;
      pc_q       <= RESET_PC;
      discard    <= 1'b0;
      skid_instr <= 32'h0;
      skid_pc    <= 32'h0;
      out_valid  <= 1'b0;
      out_instr  <= 32'h0;
      out_pc     <= 32'h0;
    end else if (branch_taken_i) begin
      pc_q      <= {branch_target_i[31:2], 2'b00};
      out_valid <= 1'b0;
      state     <= ST_REQ;
      // A request left in flight must have its response thrown away. A response
      // arriving this very cycle is dropped here, so discard only needs setting
      // when nothing came back; an already-set flag stays set because its own
      // stale response has not been seen yet.
      if (state == ST_WAIT) begin
        discard <= discard | ~imem_valid_i;
      end
    end else begin
      case (state)
        ST_REQ: begin
          if (consume) begin
            out_valid <= 1'b0;
          end
          if (fire) begin
            state <= ST_WAIT;
          end
        end
        ST_WAIT: begin
          if (imem_valid_i) begin
            if (discard) begin
              // Stale response from before a redirect: refetch the same pc.
              discard <= 1'b0;
              state   <= ST_REQ;
              if (consume) begin
                out_valid <= 1'b0;
              end
            end else if (can_accept) begin
              out_valid <= 1'b1;
              out_instr <= imem_rdata_i;
              out_pc    <= pc_q;
              pc_q      <= pc_inc;
              state     <= ST_REQ;
            end else begin
              skid_instr <= imem_rdata_i;
              skid_pc    <= pc_q;
              pc_q       <= pc_inc;
              state      <= ST_HOLD;
            end
          end else if (consume) begin
            out_valid <= 1'b0;
          end
        end
        ST_HOLD: begin
          if (!stall_i) begin
            out_valid <= 1'b1;
            out_instr <= skid_instr;
            out_pc    <= skid_pc;
            state     <= ST_REQ;
          end
        end
        default: begin
          state <= ST_REQ;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_instr_fetch.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : tb_instr_fetch
//  Description : Self-checking bench for instr_fetch. A reset-sequence vector
//                table, hand-written redirect/stall/reset sequences, and a
//                randomized run scored against an instruction-stream model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_instr_fetch;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        stall;
  logic        branch;
  logic [31:0] target;
  logic        valid;
  logic [31:0] rdata;

  logic        req,  req2;
  logic [31:0] addr, addr2;
  logic        ifv,  ifv2;
  logic [31:0] instr, instr2;
  logic [31:0] pc,   pc2;
  logic [31:0] pc4,  pc42;

  int vectors    = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  instr_fetch #(.RESET_PC(32'h0000_0000)) dut (
    .clk(clk), .rst_n(rst_n), .stall_i(stall), .branch_taken_i(branch),
    .branch_target_i(target), .imem_req_o(req), .imem_addr_o(addr),
    .imem_valid_i(valid), .imem_rdata_i(rdata), .if_valid_o(ifv),
    .if_instr_o(instr), .if_pc_o(pc), .if_pc_plus4_o(pc4)
  );

  instr_fetch #(.RESET_PC(32'hFFFF_FFFC)) dut_wrap (
    .clk(clk), .rst_n(rst_n), .stall_i(stall), .branch_taken_i(branch),
    .branch_target_i(target), .imem_req_o(req2), .imem_addr_o(addr2),
    .imem_valid_i(valid), .imem_rdata_i(rdata), .if_valid_o(ifv2),
    .if_instr_o(instr2), .if_pc_o(pc2), .if_pc_plus4_o(pc42)
  );

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h0000_0013;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic chk1(input string name, input logic act, input logic exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %b expected %b", name, act, exp);
    end
  endtask

  // Drive one cycle of inputs at the falling edge, then settle before sampling.
  task automatic drive(input logic s, input logic b, input logic [31:0] t,
                       input logic v, input logic [31:0] d);
    @(negedge clk);
    stall = s; branch = b; target = t; valid = v; rdata = d;
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0; stall = 1'b0; branch = 1'b0; target = 32'h0;
    valid = 1'b0; rdata = 32'h0;
    repeat (2) @(posedge clk);
    #2 rst_n = 1'b1;
  endtask

  typedef struct {
    logic        stall;
    logic        valid;
    logic [31:0] rdata;
    logic        e_req;
    logic [31:0] e_addr;
    logic        e_ifv;
    logic [31:0] e_pc;
    logic [31:0] e_instr;
    logic [31:0] e_addr2;
    logic [31:0] e_pc2;
  } vec_t;

  vec_t tbl [7];

  typedef struct {
    logic [31:0] addr;
    int          due;
  } pend_t;

  pend_t       q[$];
  logic        m_v, m_s, m_b, prev_hold;
  logic [31:0] m_d, m_t, exp_pc, prev_pc, prev_instr;
  int          consumed;

  initial begin
    // Reset bring-up with a one-cycle memory returning 0x13 everywhere.
    tbl[0] = '{1'b0, 1'b0, 32'h0,  1'b1, 32'h0, 1'b0, 32'h0, 32'h0,  32'hFFFF_FFFC, 32'h0};
    tbl[1] = '{1'b0, 1'b1, 32'h13, 1'b0, 32'h0, 1'b0, 32'h0, 32'h0,  32'h0,         32'h0};
    tbl[2] = '{1'b0, 1'b0, 32'h0,  1'b1, 32'h4, 1'b1, 32'h0, 32'h13, 32'h0,         32'hFFFF_FFFC};
    tbl[3] = '{1'b0, 1'b1, 32'h13, 1'b0, 32'h0, 1'b0, 32'h0, 32'h0,  32'h0,         32'hFFFF_FFFC};
    tbl[4] = '{1'b0, 1'b0, 32'h0,  1'b1, 32'h8, 1'b1, 32'h4, 32'h13, 32'h4,         32'h0};
    tbl[5] = '{1'b0, 1'b1, 32'h13, 1'b0, 32'h0, 1'b0, 32'h4, 32'h0,  32'h0,         32'h0};
    tbl[6] = '{1'b0, 1'b0, 32'h0,  1'b1, 32'hC, 1'b1, 32'h8, 32'h13, 32'h8,         32'h4};

    rst_n = 1'b0; stall = 1'b0; branch = 1'b0; target = 32'h0;
    valid = 1'b0; rdata = 32'h0;
    @(negedge clk); #1;
    chk1("rst_req", req, 1'b0);
    chk1("rst_ifv", ifv, 1'b0);
    chk("rst_instr", instr, 32'h0);
    chk("rst_pc", pc, 32'h0);
    chk("rst_pc4", pc4, 32'h4);
    chk("rst_pc4_wrapdut", pc42, 32'h4);

    do_reset();
    for (int i = 0; i < 7; i++) begin
      drive(tbl[i].stall, 1'b0, 32'h0, tbl[i].valid, tbl[i].rdata);
      chk1("tbl_req", req, tbl[i].e_req);
      if (tbl[i].e_req) chk("tbl_addr", addr, tbl[i].e_addr);
      chk1("tbl_ifv", ifv, tbl[i].e_ifv);
      chk("tbl_pc", pc, tbl[i].e_pc);
      chk("tbl_pc4", pc4, tbl[i].e_pc + 32'd4);
      if (tbl[i].e_ifv) chk("tbl_instr", instr, tbl[i].e_instr);
      chk1("tbl_req_wrapdut", req2, tbl[i].e_req);
      if (tbl[i].e_req) chk("tbl_addr_wrapdut", addr2, tbl[i].e_addr2);
      chk("tbl_pc_wrapdut", pc2, tbl[i].e_pc2);
      chk("tbl_pc4_wrapdut", pc42, tbl[i].e_pc2 + 32'd4);
    end

    // Redirect while a request is in flight; its response arrives later.
    do_reset();
    drive(1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
    chk1("br_first_req", req, 1'b1);
    drive(1'b0, 1'b1, 32'h103, 1'b0, 32'h0);
    chk1("br_no_req", req, 1'b0);
    drive(1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
    chk1("br_req", req, 1'b1);
    chk("br_req_addr", addr, 32'h100);
    drive(1'b0, 1'b0, 32'h0, 1'b1, 32'hDEAD_BEEF);
    chk1("br_wait_noreq", req, 1'b0);
    drive(1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
    chk1("br_stale_dropped", ifv, 1'b0);
    chk("br_reissue_addr", addr, 32'h100);
    drive(1'b0, 1'b0, 32'h0, 1'b1, 32'h1234_5678);
    drive(1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
    chk1("br_ifv", ifv, 1'b1);
    chk("br_pc", pc, 32'h100);
    chk("br_instr", instr, 32'h1234_5678);
    chk("br_pc4", pc4, 32'h104);

    // Redirect coincident with a response while stalled.
    drive(1'b1, 1'b1, 32'h200, 1'b1, 32'hBAD0_0001);
    drive(1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
    chk1("coinc_ifv", ifv, 1'b0);
    chk1("coinc_req", req, 1'b1);
    chk("coinc_addr", addr, 32'h200);
    drive(1'b0, 1'b0, 32'h0, 1'b1, 32'h0000_0A5A);

    // Five stalled cycles: output frozen, no requests; then consumed once.
    for (int i = 0; i < 5; i++) begin
      drive(1'b1, 1'b0, 32'h0, 1'b0, 32'h0);
      chk1("stall_ifv", ifv, 1'b1);
      chk("stall_pc", pc, 32'h200);
      chk("stall_instr", instr, 32'h0000_0A5A);
      chk1("stall_noreq", req, 1'b0);
    end
    drive(1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
    chk1("unstall_req", req, 1'b1);
    chk("unstall_addr", addr, 32'h204);
    drive(1'b0, 1'b0, 32'h0, 1'b1, 32'h0000_0204);
    chk1("no_duplicate", ifv, 1'b0);
    drive(1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
    chk("next_pc", pc, 32'h204);
    chk("next_instr", instr, 32'h0000_0204);

    // Reset asserted mid-wait; the late response must be ignored.
    drive(1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
    #2 rst_n = 1'b0;
    #1;
    chk1("async_ifv", ifv, 1'b0);
    chk1("async_req", req, 1'b0);
    chk("async_pc", pc, 32'h0);
    chk("async_instr", instr, 32'h0);
    chk("async_pc4", pc4, 32'h4);
    @(posedge clk);
    #2 rst_n = 1'b1;
    drive(1'b0, 1'b0, 32'h0, 1'b1, 32'hBAD0_0002);
    chk1("restart_req", req, 1'b1);
    chk("restart_addr", addr, 32'h0);
    drive(1'b0, 1'b0, 32'h0, 1'b1, 32'h0000_0F0F);
    chk1("late_ignored", ifv, 1'b0);
    drive(1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
    chk1("restart_ifv", ifv, 1'b1);
    chk("restart_pc", pc, 32'h0);
    chk("restart_instr", instr, 32'h0000_0F0F);

    // Randomized run: memory with 1..3 cycle latency, random stalls and
    // redirects; delivered instructions must follow the program order.
    do_reset();
    exp_pc = 32'h0;
    consumed = 0;
    prev_hold = 1'b0;
    prev_pc = 32'h0;
    prev_instr = 32'h0;
    for (int c = 0; c < 3000; c++) begin
      m_v = 1'b0;
      m_d = 32'h0;
      if (q.size() > 0 && q[0].due <= c) begin
        m_v = 1'b1;
        m_d = mem_word(q[0].addr);
        void'(q.pop_front());
      end
      m_s = ($urandom % 4) == 0;
      // Redirect only when no response is still owed after this cycle.
      m_b = (q.size() == 0) && (($urandom % 12) == 0);
      m_t = $urandom;
      drive(m_s, m_b, m_t, m_v, m_d);
      if (prev_hold) begin
        chk("rnd_hold_pc", pc, prev_pc);
        chk("rnd_hold_instr", instr, prev_instr);
      end
      if (m_b) begin
        exp_pc = {m_t[31:2], 2'b00};
      end else if (ifv && !m_s) begin
        chk("rnd_pc", pc, exp_pc);
        chk("rnd_instr", instr, mem_word(exp_pc));
        chk("rnd_pc4", pc4, exp_pc + 32'd4);
        exp_pc = exp_pc + 32'd4;
        consumed++;
      end
      if (req) begin
        chk("rnd_one_outstanding", q.size(), 32'd0);
        q.push_back('{addr, c + int'($urandom_range(1, 3))});
      end
      prev_hold = ifv & m_s & ~m_b;
      prev_pc = pc;
      prev_instr = instr;
    end
    chk("rnd_progress", (consumed > 200) ? 32'd1 : 32'd0, 32'd1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
`default_nettype wire
